// File: rtl/stopwatch_cmd_gen_pkg.sv
// Shared stopwatch encodings: status values
// reported by the control FSM and command FSM states.
package stopwatch_cmd_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } sw_status_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_WAIT = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/stopwatch_cmd_gen_btn_debounce.sv
// Button conditioning: 2-flop synchronizer,
// stable-level debounce and rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= '0;
      cnt         <= '0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], btn};
      press_pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // pulse lands in the same cycle the level flips
        level       <= sync[1];
        press_pulse <= sync[1];
        cnt         <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Turns debounced start/stop and reset buttons into
// one-cycle stopwatch commands with status acknowledge.
module stopwatch_cmd_gen
  import stopwatch_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_startstop,
  input  logic       btn_reset,
  input  logic [1:0] status,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       cmd_busy,
  output logic       err_timeout
);

  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(ACK_TIMEOUT - 1);

  logic ss_level, ss_pulse;
  logic rb_level, rb_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_startstop),
    .level      (ss_level),
    .press_pulse(ss_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rb (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_reset),
    .level      (rb_level),
    .press_pulse(rb_pulse)
  );

  cmd_state_e    state;
  sw_status_e    exp_st;
  logic [WW-1:0] wcnt;

  logic rb_press, ss_press;
  logic do_rst, do_issue, do_ack, do_tmo, do_wait;

  always_comb begin
    rb_press = rb_pulse & rb_level;
    ss_press = ss_pulse & ss_level;
    do_rst   = rb_press;
    do_issue = 1'b0;
    do_ack   = 1'b0;
    do_tmo   = 1'b0;
    do_wait  = 1'b0;
    if (!rb_press) begin
      if (state == CMD_IDLE) begin
        do_issue = ss_press;
      end else if (status == exp_st) begin
        do_ack = 1'b1;
      end else if (wcnt == WLAST) begin
        do_tmo = 1'b1;
      end else begin
        do_wait = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CMD_IDLE;
      exp_st      <= ST_IDLE;
      wcnt        <= '0;
      start       <= 1'b0;
      stop        <= 1'b0;
      reset       <= 1'b0;
      cmd_busy    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      reset <= 1'b0;
      unique case (1'b1)
        do_rst: begin
          reset       <= 1'b1;
          cmd_busy    <= 1'b0;
          err_timeout <= 1'b0;
          state       <= CMD_IDLE;
        end
        do_issue: begin
          if (status == ST_RUNNING) begin
            stop   <= 1'b1;
            exp_st <= ST_PAUSED;
          end else begin
            start  <= 1'b1;
            exp_st <= ST_RUNNING;
          end
          wcnt     <= '0;
          cmd_busy <= 1'b1;
          state    <= CMD_WAIT;
        end
        do_ack: begin
          cmd_busy <= 1'b0;
          state    <= CMD_IDLE;
        end
        do_tmo: begin
          cmd_busy    <= 1'b0;
          err_timeout <= 1'b1;
          state       <= CMD_IDLE;
        end
        do_wait: begin
          wcnt <= wcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Directed vector bench for stopwatch_cmd_gen with a
// second long-timeout instance for the busy-drop case.
module tb_stopwatch_cmd_gen;

  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] P = 5'b01000;
  localparam logic [4:0] R = 5'b00100;
  localparam logic [4:0] B = 5'b00010;
  localparam logic [4:0] E = 5'b00001;

  typedef struct {
    string      name;
    int         n;
    logic       rst;
    logic       ss;
    logic       rb;
    logic [1:0] st;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_ss = 1'b0, btn_rb = 1'b0;
  logic [1:0] status = 2'b00;
  logic start, stop, reset, busy, err;

  logic btn_ss2 = 1'b0;
  logic start2, stop2, reset2, busy2, err2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_cmd_gen #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_startstop(btn_ss),
    .btn_reset    (btn_rb),
    .status       (status),
    .start        (start),
    .stop         (stop),
    .reset        (reset),
    .cmd_busy     (busy),
    .err_timeout  (err)
  );

  stopwatch_cmd_gen #(.DEBOUNCE_CYCLES(1), .ACK_TIMEOUT(16)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .btn_startstop(btn_ss2),
    .btn_reset    (1'b0),
    .status       (2'b00),
    .start        (start2),
    .stop         (stop2),
    .reset        (reset2),
    .cmd_busy     (busy2),
    .err_timeout  (err2)
  );

  task automatic row(input string nm, input int n,
                     input logic r, input logic ss,
                     input logic rb, input logic [1:0] st,
                     input logic [4:0] ex);
    vec_t v;
    v.name = nm; v.n = n; v.rst = r; v.ss = ss;
    v.rb = rb; v.st = st; v.exp = ex;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0] got;
    logic [3:0] got2, exp2;
    int cyc;

    row("reset_state", 2, 1, 0, 0, 2'd0, 5'b0);
    // clean press, start at edge 7, ack two cycles later
    row("a_deb",   6, 0, 1, 0, 2'd0, 5'b0);
    row("a_start", 1, 0, 1, 0, 2'd0, S | B);
    row("a_busy",  1, 0, 1, 0, 2'd0, B);
    row("a_ack",  12, 0, 1, 0, 2'd1, 5'b0);
    row("a_rel",   8, 0, 0, 0, 2'd1, 5'b0);
    // bounce then stable, stop
    row("b_b1",    2, 0, 1, 0, 2'd1, 5'b0);
    row("b_b0",    2, 0, 0, 0, 2'd1, 5'b0);
    row("b_b1",    2, 0, 1, 0, 2'd1, 5'b0);
    row("b_b0",    2, 0, 0, 0, 2'd1, 5'b0);
    row("b_deb",   6, 0, 1, 0, 2'd1, 5'b0);
    row("b_stop",  1, 0, 1, 0, 2'd1, P | B);
    row("b_busy",  1, 0, 1, 0, 2'd1, B);
    row("b_ack",   1, 0, 1, 0, 2'd2, 5'b0);
    row("b_rel",   8, 0, 0, 0, 2'd2, 5'b0);
    // timeout then reset button clears error
    row("c_deb",   6, 0, 1, 0, 2'd2, 5'b0);
    row("c_start", 1, 0, 1, 0, 2'd2, S | B);
    row("c_busy",  3, 0, 1, 0, 2'd2, B);
    row("c_tmo",   1, 0, 1, 0, 2'd2, E);
    row("c_sticky",5, 0, 1, 0, 2'd2, E);
    row("c_rel",   8, 0, 0, 0, 2'd2, E);
    row("c_rdeb",  6, 0, 0, 1, 2'd2, E);
    row("c_rpulse",1, 0, 0, 1, 2'd2, R);
    row("c_rhold", 5, 0, 0, 1, 2'd2, 5'b0);
    row("c_rrel",  8, 0, 0, 0, 2'd2, 5'b0);
    // both buttons together
    row("d_deb",   6, 0, 1, 1, 2'd0, 5'b0);
    row("d_rpulse",1, 0, 1, 1, 2'd0, R);
    row("d_hold",  5, 0, 1, 1, 2'd0, 5'b0);
    row("d_rel",   8, 0, 0, 0, 2'd0, 5'b0);
    // rst mid-debounce
    row("f_deb",   2, 0, 1, 0, 2'd0, 5'b0);
    row("f_rst",   1, 1, 1, 0, 2'd0, 5'b0);
    row("f_rst",   1, 1, 0, 0, 2'd0, 5'b0);
    row("f_quiet",10, 0, 0, 0, 2'd0, 5'b0);
    // held across rst, then rst mid-wait
    row("g_rst",   2, 1, 1, 0, 2'd0, 5'b0);
    row("g_deb",   6, 0, 1, 0, 2'd0, 5'b0);
    row("g_start", 1, 0, 1, 0, 2'd0, S | B);
    row("g_busy",  1, 0, 1, 0, 2'd0, B);
    row("g_rst",   1, 1, 0, 0, 2'd0, 5'b0);
    row("g_quiet",10, 0, 0, 0, 2'd0, 5'b0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst    = tbl[i].rst;
        btn_ss = tbl[i].ss;
        btn_rb = tbl[i].rb;
        status = tbl[i].st;
        @(posedge clk);
        #1;
        got = {start, stop, reset, busy, err};
        n_chk++;
        if (got !== tbl[i].exp) begin
          n_fail++;
          $display("FAIL %s row %0d cyc %0d: got %b want %b",
                   tbl[i].name, i, k, got, tbl[i].exp);
        end
      end
    end

    // toggle press while busy is dropped (D=1, timeout 16)
    for (cyc = 1; cyc <= 24; cyc++) begin
      btn_ss2 = (cyc <= 4) || (cyc >= 8 && cyc <= 12);
      @(posedge clk);
      #1;
      got2 = {start2, stop2 | reset2, busy2, err2};
      exp2 = {cyc == 4, 1'b0, cyc >= 4 && cyc < 20, cyc >= 20};
      n_chk++;
      if (got2 !== exp2) begin
        n_fail++;
        $display("FAIL busy_drop cyc %0d: got %b want %b",
                 cyc, got2, exp2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_cmd_gen.md
STOPWATCH_CMD_GEN -- requirements
Module: stopwatch_cmd_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; consecutive stable cycles needed to accept a button level change (>=1).
REQ-002 Parameter ACK_TIMEOUT, default 4; maximum cycles to wait for status to confirm an issued command (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_startstop  input  1  raw, asynchronous, bouncing start/stop toggle button; active-high.
REQ-006 btn_reset  input  1  raw, asynchronous, bouncing reset button; active-high.
REQ-007 status  input  2  stopwatch state: 00 IDLE, 01 RUNNING, 10 PAUSED; 11 is treated as IDLE.
REQ-008 start  output  1  one-cycle command pulse to enter RUNNING.
REQ-009 stop  output  1  one-cycle command pulse to enter PAUSED.
REQ-010 reset  output  1  one-cycle command pulse to return to IDLE.
REQ-011 cmd_busy  output  1  high while CMD_WAIT is active.
REQ-012 err_timeout  output  1  sticky flag: a command was not confirmed within ACK_TIMEOUT cycles.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce, per button: a counter SHALL increment while the synchronized level differs from the stable level.
- The counter SHALL clear on any cycle where the levels match.
- On reaching DEBOUNCE_CYCLES, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 A press event SHALL be a 0->1 transition of the stable level. It lasts one cycle. Release events produce no command.
REQ-016 All outputs SHALL be registered.
REQ-017 A clean press held constant SHALL produce its command pulse exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw input high.
REQ-018 Command FSM states: CMD_IDLE and CMD_WAIT.
REQ-019 reset press, in any FSM state: the reset pulse SHALL be issued, cmd_busy cleared, err_timeout cleared, and the next state SHALL be CMD_IDLE.
REQ-020 Toggle press in CMD_IDLE, command selection:
- status RUNNING -> stop pulse; expected status = PAUSED.
- otherwise -> start pulse; expected status = RUNNING.
- Next state SHALL be CMD_WAIT, with the wait counter cleared.
REQ-021 In CMD_WAIT, toggle presses SHALL be dropped with no output.
REQ-022 CMD_WAIT exits to CMD_IDLE when status equals the expected value.
REQ-023 CMD_WAIT also exits to CMD_IDLE after ACK_TIMEOUT cycles without a match; err_timeout SHALL then be set in that same transition.
REQ-024 Reset press and toggle press in the same cycle: reset SHALL win and the toggle press is discarded.
REQ-025 At most one of start/stop/reset SHALL be high in any cycle.
REQ-026 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-027 A held button SHALL produce exactly one command.

Reset
REQ-028 While rst is high, on a clock edge all flops SHALL clear: synchronizers, stable levels, debounce and wait counters, outputs to 0, FSM to CMD_IDLE.
REQ-029 A button held high across rst deassertion SHALL be treated as a new press after the normal debounce latency.
REQ-030 rst asserted mid-debounce or mid-CMD_WAIT SHALL abort the operation with no pulse emitted.

Structure
REQ-031 Status encodings (IDLE/RUNNING/PAUSED) and the command FSM state encodings SHALL live in the shared stopwatch package used by the stopwatch control FSM.
REQ-032 Synchronizer, debounce and edge detect SHALL be one sub-module, btn_debounce, with parameter DEBOUNCE_CYCLES and outputs level and press_pulse; it is instantiated twice.

Verification (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=4)
REQ-033 status=00, clean btn_startstop press held 20 cycles -> single start pulse at edge 7; cmd_busy high; status driven to 01 two cycles later -> cmd_busy low.
REQ-034 status=01, btn_startstop bounces 1-0-1-0 at 2-cycle spacing, then held stable -> no pulse during bounce, exactly one stop pulse, 7 edges after the final stable high.
REQ-035 Command issued, status held unchanged -> cmd_busy high 4 cycles, then err_timeout=1 and back to CMD_IDLE; subsequent reset press -> reset pulse and err_timeout=0.
REQ-036 Both buttons pressed on the same edge -> only reset pulse, start/stop stay 0.
REQ-037 Second toggle press while cmd_busy=1 -> no pulse.
REQ-038 rst asserted 2 cycles into debounce -> no pulse.
